// File: rtl/vcap_pkg.sv
// Shared types for the camera capture packer: FSM states, word geometry and
// the FIFO entry layout.
package vcap_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int VID_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } vcap_state_e;

  typedef struct packed {
    logic [VID_W-1:0] data;
    logic             sof;
    logic             eol;
  } vcap_entry_t;

endpackage

// File: rtl/vcap_sync_fifo.sv
// Single-clock FIFO; the head entry is read straight out of storage flops so a
// word written in cycle N is visible in cycle N+1, and the output reads 0 when empty.
module vcap_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_capture_packer.sv
// Packs the 8-bit camera stream four pixels per word into a FIFO feeding the VPU,
// with frame/overflow error tracking and frame/drop counters.
module video_capture_packer
  import vcap_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cam_pix_valid,
  input  logic [PIX_W-1:0] cam_pix_data,
  input  logic             cam_sof,
  input  logic             cam_eol,
  output logic [31:0]      vid_data,
  output logic             vid_valid,
  input  logic             vid_ready,
  output logic             vid_sof,
  output logic             vid_eol,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clear_status,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  vcap_state_e state_q, state_d;
  logic [1:0]  lane_q, lane_d, lane_eff;
  logic [PIX_PER_WORD-1:0][PIX_W-1:0] pix_q, pix_d, word_pix;
  logic        first_q, first_d;
  logic        line_open_q, line_open_d;
  logic        overflow_q, frame_err_q;
  logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;

  logic restart, take, push, ovf_set, err_set, frame_inc, drop_inc;
  logic fifo_wr, fifo_pop, fifo_full, fifo_empty;
  vcap_entry_t wr_entry, rd_entry;

  // A frame-starting pixel always lands in lane 0; otherwise it continues the word.
  assign lane_eff = (state_q == ST_ACTIVE && !cam_sof) ? lane_q : 2'd0;

  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign word_pix[gi] = (LANE < lane_eff)  ? pix_q[gi]    :
                            (LANE == lane_eff) ? cam_pix_data : '0;
    end
  endgenerate

  assign fifo_pop      = !fifo_empty && vid_ready;
  assign wr_entry.data = word_pix;
  assign wr_entry.sof  = restart || first_q;
  assign wr_entry.eol  = cam_eol;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pix_d       = pix_q;
    first_d     = first_q;
    line_open_d = line_open_q;
    restart     = 1'b0;
    take        = 1'b0;
    push        = 1'b0;
    ovf_set     = 1'b0;
    err_set     = 1'b0;
    frame_inc   = 1'b0;
    drop_inc    = 1'b0;
    fifo_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cam_pix_valid && cam_sof && enable) restart = 1'b1;
      end
      ST_ACTIVE: begin
        if (cam_pix_valid) begin
          if (cam_sof) begin
            err_set = (lane_q != 2'd0) || line_open_q;
            if (enable) begin
              restart = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              lane_d      = 2'd0;
              line_open_d = 1'b0;
            end
          end else begin
            take = 1'b1;
          end
        end
      end
      ST_DROP: begin
        // Track lanes so each word that would have been built is counted.
        if (cam_pix_valid) begin
          if (cam_sof) begin
            lane_d = 2'd0;
            if (enable) restart = 1'b1;
            else        state_d = ST_IDLE;
          end else if (cam_eol || lane_q == 2'd3) begin
            drop_inc = 1'b1;
            lane_d   = 2'd0;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d     = ST_ACTIVE;
      frame_inc   = 1'b1;
      take        = 1'b1;
      line_open_d = 1'b0;
    end

    if (take) begin
      line_open_d = !cam_eol;
      push        = cam_eol || (lane_eff == 2'd3);
      if (push) begin
        lane_d  = 2'd0;
        first_d = 1'b0;
        if (fifo_full && !fifo_pop) begin
          ovf_set  = 1'b1;
          drop_inc = 1'b1;
          state_d  = ST_DROP;
        end else begin
          fifo_wr = 1'b1;
        end
      end else begin
        pix_d[lane_eff] = cam_pix_data;
        lane_d          = lane_eff + 2'd1;
        first_d         = restart || first_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lane_q      <= 2'd0;
      pix_q       <= '0;
      first_q     <= 1'b0;
      line_open_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      pix_q       <= pix_d;
      first_q     <= first_d;
      line_open_q <= line_open_d;
      // A new error event in the same cycle as clear_status keeps the flag set.
      if (ovf_set)           overflow_q  <= 1'b1;
      else if (clear_status) overflow_q  <= 1'b0;
      if (err_set)           frame_err_q <= 1'b1;
      else if (clear_status) frame_err_q <= 1'b0;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + CNT_ONE;
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  vcap_sync_fifo #(
    .WIDTH ($bits(vcap_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (fifo_pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign vid_data    = rd_entry.data;
  assign vid_sof     = rd_entry.sof;
  assign vid_eol     = rd_entry.eol;
  assign vid_valid   = !fifo_empty;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_video_capture_packer.sv
// Directed bench for video_capture_packer: packing, flags, overflow/DROP,
// mid-frame sof, backpressure stability and mid-line reset.
module tb_video_capture_packer;

  logic        clk = 1'b0;
  logic        reset_n, enable, cam_pix_valid, cam_sof, cam_eol, vid_ready, clear_status;
  logic [7:0]  cam_pix_data;
  logic [31:0] vid_data;
  logic        vid_valid, vid_sof, vid_eol, overflow, frame_err;
  logic [15:0] frame_count, drop_count;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic        toggle_en = 1'b0;
  logic [33:0] words[$];
  logic        stall_seen = 1'b0;
  logic [33:0] held_word = '0;
  logic [33:0] exp_word;

  always #5 clk = ~clk;

  video_capture_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .cam_pix_valid (cam_pix_valid),
    .cam_pix_data  (cam_pix_data),
    .cam_sof       (cam_sof),
    .cam_eol       (cam_eol),
    .vid_data      (vid_data),
    .vid_valid     (vid_valid),
    .vid_ready     (vid_ready),
    .vid_sof       (vid_sof),
    .vid_eol       (vid_eol),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .clear_status  (clear_status),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Collects accepted words and checks the output holds while stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk_cnt++;
        assert (vid_valid === 1'b1 && {vid_sof, vid_eol, vid_data} === held_word) else begin
          err_cnt++;
          $error("FAIL stall_hold observed=0x%0h valid=%0b expected=0x%0h",
                 {vid_sof, vid_eol, vid_data}, vid_valid, held_word);
        end
      end
      if (vid_valid && vid_ready) words.push_back({vid_sof, vid_eol, vid_data});
      stall_seen = vid_valid && !vid_ready;
      held_word  = {vid_sof, vid_eol, vid_data};
    end
  end

  task automatic pix(input logic [7:0] d, input logic s, input logic e);
    cam_pix_valid = 1'b1;
    cam_pix_data  = d;
    cam_sof       = s;
    cam_eol       = e;
    if (toggle_en) vid_ready = ~vid_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cam_pix_valid = 1'b0;
    cam_sof       = 1'b0;
    cam_eol       = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (toggle_en) vid_ready = ~vid_ready;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; cam_pix_valid = 1'b0; cam_pix_data = '0;
    cam_sof = 1'b0; cam_eol = 1'b0; vid_ready = 1'b1; clear_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vid_valid, 0);
    chk("rst_data", {vid_sof, vid_eol, vid_data}, 0);
    chk("rst_status", {overflow, frame_err}, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    idle(2);

    // Two full words, first-word latency
    pix(8'h01, 1, 0); pix(8'h02, 0, 0); pix(8'h03, 0, 0); pix(8'h04, 0, 0);
    chk("t1_latency_valid", vid_valid, 1);
    chk("t1_latency_word", {vid_sof, vid_eol, vid_data}, {2'b10, 32'h04030201});
    pix(8'h05, 0, 0); pix(8'h06, 0, 0); pix(8'h07, 0, 0); pix(8'h08, 0, 1);
    idle(3);
    chk("t1_word_count", words.size(), 2);
    chk("t1_word0", words[0], {2'b10, 32'h04030201});
    chk("t1_word1", words[1], {2'b01, 32'h08070605});
    chk("t1_frame_count", frame_count, 1);
    words.delete();

    // Short tail word with eol
    for (int i = 0; i < 5; i++) pix(8'(8'hA1 + i), 0, i == 4);
    idle(3);
    chk("t2_word_count", words.size(), 2);
    chk("t2_word0", words[0], {2'b00, 32'hA4A3A2A1});
    chk("t2_word1", words[1], {2'b01, 32'h000000A5});
    words.delete();

    // Mid-frame sof after two pixels
    pix(8'h11, 1, 0); pix(8'h12, 0, 0);
    chk("t4_clean_sof_no_err", frame_err, 0);
    pix(8'h21, 1, 0);
    chk("t4_frame_err", frame_err, 1);
    pix(8'h22, 0, 0); pix(8'h23, 0, 0); pix(8'h24, 0, 1);
    idle(3);
    chk("t4_word_count", words.size(), 1);
    chk("t4_word0", words[0], {2'b11, 32'h24232221});
    chk("t4_frame_count", frame_count, 3);
    clear_status = 1'b1;
    idle(1);
    clear_status = 1'b0;
    chk("t4_err_cleared", frame_err, 0);
    words.delete();

    // Ready toggling every cycle
    toggle_en = 1'b1;
    for (int i = 0; i < 12; i++) pix(8'(8'h31 + i), i == 0, i == 11);
    idle(10);
    toggle_en = 1'b0;
    vid_ready = 1'b1;
    chk("t5_word_count", words.size(), 3);
    chk("t5_word0", words[0], {2'b10, 32'h34333231});
    chk("t5_word1", words[1], {2'b00, 32'h38373635});
    chk("t5_word2", words[2], {2'b01, 32'h3C3B3A39});
    chk("t5_frame_count", frame_count, 4);
    chk("t5_no_err", frame_err, 0);
    words.delete();

    // Overflow into DROP with the sink stalled
    vid_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 80; i++) pix(8'(i), i == 0, 0);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_count", drop_count, 4);
    chk("t3_head_word", {vid_valid, vid_sof, vid_eol, vid_data}, {3'b110, 32'h03020100});
    chk("t3_frame_count", frame_count, 5);
    for (int i = 0; i < 4; i++) pix(8'(8'hF0 + i), 0, 0);
    chk("t3_drop_state_count", drop_count, 5);
    vid_ready = 1'b1;
    idle(20);
    chk("t3_drain_count", words.size(), 16);
    for (int k = 0; k < 16; k++) begin
      exp_word = {(k == 0), 1'b0, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      chk($sformatf("t3_drain_word%0d", k), words[k], exp_word);
    end
    words.delete();
    pix(8'h51, 1, 0); pix(8'h52, 0, 0); pix(8'h53, 0, 0); pix(8'h54, 0, 1);
    idle(3);
    chk("t3_resume_count", words.size(), 1);
    chk("t3_resume_word", words[0], {2'b11, 32'h54535251});
    chk("t3_resume_frame_count", frame_count, 6);
    chk("t3_overflow_sticky", overflow, 1);
    clear_status = 1'b1;
    idle(1);
    clear_status = 1'b0;
    chk("t3_overflow_cleared", overflow, 0);
    words.delete();

    // Push and pop on the same edge while full
    vid_ready = 1'b0;
    for (int i = 0; i < 67; i++) pix(8'(i), i == 0, 0);
    chk("t3b_full_no_ovf", overflow, 0);
    vid_ready = 1'b1;
    pix(8'd67, 0, 0);
    chk("t3b_push_pop_full_no_ovf", overflow, 0);
    chk("t3b_drop_unchanged", drop_count, 5);
    idle(20);
    chk("t3b_word_count", words.size(), 17);
    chk("t3b_word0", words[0], {2'b10, 32'h03020100});
    chk("t3b_word16", words[16], {2'b00, 32'h43424140});
    chk("t3b_frame_count", frame_count, 7);
    words.delete();

    // sof with the line still open, then reset with words buffered
    vid_ready = 1'b0;
    for (int i = 0; i < 14; i++) pix(8'(8'h61 + i), i == 0, 0);
    chk("t6_err_line_open", frame_err, 1);
    chk("t6_buffered_valid", vid_valid, 1);
    chk("t6_frame_count", frame_count, 8);
    idle(1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", vid_valid, 0);
    chk("t6_rst_counters", {frame_count, drop_count}, 0);
    chk("t6_rst_status", {overflow, frame_err}, 0);
    reset_n   = 1'b1;
    vid_ready = 1'b1;
    idle(1);
    words.delete();
    for (int i = 0; i < 4; i++) pix(8'(8'h71 + i), 0, i == 3);
    idle(3);
    chk("t6_idle_ignores_pixels", words.size(), 0);
    enable = 1'b0;
    pix(8'h81, 1, 0); pix(8'h82, 0, 1);
    idle(3);
    chk("t6_disabled_sof_ignored", {16'(words.size()), frame_count}, 0);
    enable = 1'b1;
    pix(8'h91, 1, 1);
    idle(3);
    chk("t6_single_pixel_count", words.size(), 1);
    chk("t6_single_pixel_word", words[0], {2'b11, 32'h00000091});
    chk("t6_frame_count_after", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
